// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: receive-to-transmit echo buffer on an inferred circular RAM,
// with an occupancy counter, full/empty, sticky overflow and a one-byte-outstanding
// transmit handshake. Define ECHO_LINE_MODE_EN to hold bytes until a LINE_TERM arrives.
module uart_echo_fifo #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 9,
  parameter logic [DATA_W-1:0]  LINE_TERM = 'h0D
) (
  input  logic              ICE_CLK,
  input  logic              RST_N,
  input  logic              rx_dv,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              tx_done,
  output logic              tx_dv,
  output logic [DATA_W-1:0] tx_byte,
  output logic [ADDR_W:0]   fill_level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [2:0]        state;
  logic              push;
  logic              pop;
  logic              launch;

  // Occupancy comes from the counter alone, so full and empty never alias.
  assign empty = (fill_level == '0);
  assign full  = (fill_level == FILL_MAX);
  assign push  = rx_dv && !full;
  assign pop   = (state == S_IDLE) && launch;

`ifdef ECHO_LINE_MODE_EN
  logic [ADDR_W:0] lines_pending;
  logic            flush;
  logic            term_in;
  logic            term_out;

  assign term_in  = push && (rx_byte == LINE_TERM);
  assign term_out = (state == S_READ) && (rd_data == LINE_TERM);
  assign launch   = !empty && tx_done && ((lines_pending != '0) || full || flush);

  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      lines_pending <= '0;
      flush         <= 1'b0;
    end else begin
      case ({term_in, term_out})
        2'b10:   lines_pending <= lines_pending + 1'b1;
        2'b01:   lines_pending <= lines_pending - 1'b1;
        default: ;
      endcase
      // A full buffer with no terminator drains completely to avoid deadlock.
      if (full)       flush <= 1'b1;
      else if (empty) flush <= 1'b0;
    end
  end
`else
  assign launch = !empty && tx_done;
`endif

  // NOTE: the RAM array has no reset so it maps onto block RAM; the pointers and
  // occupancy counter that qualify its contents are the state that gets reset.
  always_ff @(posedge ICE_CLK) begin
    if (push) mem[wr_ptr] <= rx_byte;
    if (pop)  rd_data     <= mem[rd_ptr];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; a same-address read therefore returns old data.
  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: ;
      endcase
      if (rx_dv && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

  // tx_dv is raised on entry to SEND so it is high for exactly the SEND cycle.
  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      tx_dv   <= 1'b0;
      tx_byte <= '0;
    end else begin
      tx_dv <= 1'b0;
      case (state)
        S_IDLE:    if (launch) state <= S_READ;
        S_READ: begin
          tx_byte <= rd_data;
          tx_dv   <= 1'b1;
          state   <= S_SEND;
        end
        S_SEND:    state <= S_WAIT_LO;
        S_WAIT_LO: if (!tx_done) state <= S_WAIT_HI;
        S_WAIT_HI: if (tx_done)  state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo (ADDR_W=4, DEPTH=16) with a simple
// transmitter model that drops tx_done for a few cycles after each launch.
module tb_uart_echo_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              ICE_CLK = 1'b0;
  logic              RST_N   = 1'b0;
  logic              rx_dv   = 1'b0;
  logic [DATA_W-1:0] rx_byte = '0;
  logic              ovf_clr = 1'b0;
  logic              tx_done;
  logic              tx_dv;
  logic [DATA_W-1:0] tx_byte;
  logic [ADDR_W:0]   fill_level;
  logic              empty;
  logic              full;
  logic              overflow;

  uart_echo_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_TERM(8'h0D)) dut (
    .ICE_CLK   (ICE_CLK),
    .RST_N     (RST_N),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .tx_done   (tx_done),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .fill_level(fill_level),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 ICE_CLK = ~ICE_CLK;

  // Transmitter model: records each launch and stays busy for three cycles.
  logic       tx_hold  = 1'b1;
  logic       model_en = 1'b1;
  int         busy     = 0;
  int         n_tx     = 0;
  logic [7:0] got   [$];
  logic [7:0] exp_q [$];

  assign tx_done = !tx_hold && (busy == 0);

  always @(negedge ICE_CLK) begin
    if (!RST_N) begin
      busy = 0;
    end else if (tx_dv) begin
      got.push_back(tx_byte);
      n_tx++;
      if (model_en) busy = 3;
    end else if (busy > 0) begin
      busy--;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge ICE_CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    step();
    rx_dv   = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, got.size(), n);
  endtask

  task automatic check_seq(input string name);
    check({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fill"},     fill_level, 0);
    check({tag, "_empty"},    empty,      1);
    check({tag, "_full"},     full,       0);
    check({tag, "_overflow"}, overflow,   0);
    check({tag, "_tx_dv"},    tx_dv,      0);
    check({tag, "_tx_byte"},  tx_byte,    0);
  endtask

  // Cumulative fill/overflow table applied while the transmitter is held busy.
  typedef struct {
    int         n_push;
    logic       clr;
    logic [4:0] exp_fill;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ovf;
  } row_t;

  row_t tbl [8];

  initial begin
    tbl[0] = '{n_push: 0,  clr: 1'b0, exp_fill: 5'd0,  exp_empty: 1'b1, exp_full: 1'b0, exp_ovf: 1'b0};
    tbl[1] = '{n_push: 1,  clr: 1'b0, exp_fill: 5'd1,  exp_empty: 1'b0, exp_full: 1'b0, exp_ovf: 1'b0};
    tbl[2] = '{n_push: 4,  clr: 1'b0, exp_fill: 5'd5,  exp_empty: 1'b0, exp_full: 1'b0, exp_ovf: 1'b0};
    tbl[3] = '{n_push: 10, clr: 1'b0, exp_fill: 5'd15, exp_empty: 1'b0, exp_full: 1'b0, exp_ovf: 1'b0};
    tbl[4] = '{n_push: 1,  clr: 1'b0, exp_fill: 5'd16, exp_empty: 1'b0, exp_full: 1'b1, exp_ovf: 1'b0};
    tbl[5] = '{n_push: 2,  clr: 1'b0, exp_fill: 5'd16, exp_empty: 1'b0, exp_full: 1'b1, exp_ovf: 1'b1};
    tbl[6] = '{n_push: 1,  clr: 1'b1, exp_fill: 5'd16, exp_empty: 1'b0, exp_full: 1'b1, exp_ovf: 1'b1};
    tbl[7] = '{n_push: 0,  clr: 1'b1, exp_fill: 5'd16, exp_empty: 1'b0, exp_full: 1'b1, exp_ovf: 1'b0};

    repeat (3) step();
    check_reset_outputs("reset");
    RST_N   = 1'b1;
    tx_hold = 1'b0;
    step();

`ifdef ECHO_LINE_MODE_EN
    got.delete();
    push_byte(8'h41);
    push_byte(8'h42);
    repeat (15) step();
    check("line_no_tx_before_term", n_tx, 0);
    push_byte(8'h0D);
    wait_got(3, 100, "line_wait");
    exp_q = '{8'h41, 8'h42, 8'h0D};
    check_seq("line_echo");
`else
    begin : latency_and_order
      int lat = 0;
      got.delete();
      rx_dv   = 1'b1;
      rx_byte = 8'h41;
      do begin
        step();
        rx_dv = 1'b0;
        lat++;
      end while (!tx_dv && lat < 10);
      check("latency_cycles", lat, 3);
      check("first_tx_byte", tx_byte, 8'h41);
      push_byte(8'h42);
      push_byte(8'h43);
      wait_got(3, 100, "abc_wait");
      exp_q = '{8'h41, 8'h42, 8'h43};
      check_seq("abc_echo");
      repeat (10) step();
      check("abc_tx_count", n_tx, 3);
      check("abc_fill", fill_level, 0);
      check("abc_empty", empty, 1);
    end

    begin : fill_table
      logic [7:0] d = 8'h60;
      tx_hold = 1'b1;
      got.delete();
      n_tx = 0;
      for (int r = 0; r < 8; r++) begin
        ovf_clr = tbl[r].clr;
        if (tbl[r].n_push == 0) step();
        for (int p = 0; p < tbl[r].n_push; p++) begin
          push_byte(d);
          d++;
        end
        ovf_clr = 1'b0;
        check($sformatf("tbl%0d_fill", r),  fill_level, tbl[r].exp_fill);
        check($sformatf("tbl%0d_empty", r), empty,      tbl[r].exp_empty);
        check($sformatf("tbl%0d_full", r),  full,       tbl[r].exp_full);
        check($sformatf("tbl%0d_ovf", r),   overflow,   tbl[r].exp_ovf);
      end
      check("held_no_tx", n_tx, 0);
      tx_hold = 1'b0;
      wait_got(DEPTH, 400, "full_drain_wait");
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'h60 + 8'(i));
      check_seq("full_drain");
      repeat (20) step();
      check("full_drain_tx_count", n_tx, DEPTH);
      check("full_drain_empty", empty, 1);
    end

    begin : concurrent_push_pop
      tx_hold = 1'b1;
      got.delete();
      for (int i = 0; i < 5; i++) push_byte(8'h80 + 8'(i));
      check("conc_fill_before", fill_level, 5);
      tx_hold = 1'b0;
      push_byte(8'h55);
      tx_hold = 1'b1;
      check("conc_fill_after", fill_level, 5);
      tx_hold = 1'b0;
      wait_got(6, 200, "conc_wait");
      exp_q = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h55};
      check_seq("conc_echo");
    end

    begin : wrap_stream
      got.delete();
      for (int i = 0; i < 40; i++) begin
        push_byte(8'(i));
        repeat (7) step();
      end
      wait_got(40, 200, "wrap_wait");
      exp_q.delete();
      for (int i = 0; i < 40; i++) exp_q.push_back(8'(i));
      check_seq("wrap_echo");
      check("wrap_overflow", overflow, 0);
    end

    begin : reset_mid_transfer
      int k = 0;
      int tx_before;
      repeat (10) step();
      tx_hold = 1'b1;
      for (int i = 0; i < 4; i++) push_byte(8'h90 + 8'(i));
      model_en = 1'b0;
      tx_hold  = 1'b0;
      while (!tx_dv && k < 20) begin
        step();
        k++;
      end
      check("rst_saw_launch", tx_dv, 1);
      repeat (2) step();
      check("rst_fill_before", fill_level, 3);
      RST_N = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      repeat (2) step();
      RST_N    = 1'b1;
      model_en = 1'b1;
      tx_before = n_tx;
      repeat (30) step();
      check("rst_no_tx_after", n_tx, tx_before);
      check("rst_empty_after", empty, 1);
      got.delete();
      push_byte(8'hA5);
      wait_got(1, 50, "rst_new_wait");
      exp_q = '{8'hA5};
      check_seq("rst_new_echo");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
